// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared state encoding, master indices and burst-counter sizing for mem_arbiter
`ifndef ADDR_SIZE
`define ADDR_SIZE 16
`endif
`ifndef WORD_SIZE
`define WORD_SIZE 16
`endif

package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GNT0 = 2'd1,
    GNT1 = 2'd2
  } state_t;

  localparam logic M_CPU = 1'b0;
  localparam logic M_LDR = 1'b1;

  function automatic int burst_w(input int max_burst);
    return $clog2(max_burst + 1);
  endfunction

endpackage

// File: rtl/arb_pick.sv
// rtl/arb_pick.sv - combinational next-owner picker; ARB_FIXED_PRIO_EN makes the loader win every arbitration
module arb_pick
  import mem_arb_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last_gnt,
  input  logic       cur_owner,
  input  logic       granted,
  input  logic       hold,
  input  logic       force_sw,
  output logic       nxt_valid,
  output logic       nxt_owner
);

  always_comb begin
    nxt_valid = 1'b0;
    nxt_owner = cur_owner;
`ifdef ARB_FIXED_PRIO_EN
    // Only the CPU can be pushed off by the burst cap.
    if (granted && hold && !(force_sw && cur_owner == M_CPU)) begin
      nxt_valid = 1'b1;
    end else if (|req) begin
      nxt_valid = 1'b1;
      nxt_owner = req[M_LDR] ? M_LDR : M_CPU;
    end
`else
    if (granted && hold && !force_sw) begin
      nxt_valid = 1'b1;
    end else if (req == 2'b11) begin
      // A forced switch treats the current owner as the last one served.
      nxt_valid = 1'b1;
      nxt_owner = granted ? ~cur_owner : ~last_gnt;
    end else if (|req) begin
      nxt_valid = 1'b1;
      nxt_owner = req[M_LDR];
    end
`endif
  end

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - two-master single-port RAM arbiter with burst cap, lock and read-return tag; ARB_FIXED_PRIO_EN selects loader priority
`ifndef ADDR_SIZE
`define ADDR_SIZE 16
`endif
`ifndef WORD_SIZE
`define WORD_SIZE 16
`endif

module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W    = `ADDR_SIZE,
  parameter int DATA_W    = `WORD_SIZE,
  parameter int MAX_BURST = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              m0_req,
  input  logic              m0_we,
  input  logic              m0_lock,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic              m0_gnt,
  output logic              m0_rvalid,
  output logic [DATA_W-1:0] m0_rdata,
  input  logic              m1_req,
  input  logic              m1_we,
  input  logic              m1_lock,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic              m1_gnt,
  output logic              m1_rvalid,
  output logic [DATA_W-1:0] m1_rdata,
  output logic              mem_wr_en,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int CW = burst_w(MAX_BURST);
  localparam logic [CW-1:0] CNT_MAX = CW'(MAX_BURST);

  state_t          state, state_nxt;
  logic            last_gnt;
  logic [CW-1:0]   burst_cnt, cnt_inc;
  logic            rd_vld_q, rd_own_q;

  logic            granted, owner, req_cur, we_cur, lock_cur, req_oth;
  logic            xfer, hold, force_sw, nxt_valid, nxt_owner;
  logic [ADDR_W-1:0] addr_cur;
  logic [DATA_W-1:0] wdata_cur;

  always_comb begin
    granted   = (state != IDLE);
    owner     = (state == GNT1) ? M_LDR : M_CPU;
    req_cur   = owner ? m1_req   : m0_req;
    we_cur    = owner ? m1_we    : m0_we;
    lock_cur  = owner ? m1_lock  : m0_lock;
    addr_cur  = owner ? m1_addr  : m0_addr;
    wdata_cur = owner ? m1_wdata : m0_wdata;
    req_oth   = owner ? m0_req   : m1_req;
    xfer      = granted & req_cur;
    hold      = req_cur | lock_cur;
    // Count includes this cycle's transfer so the switch lands right after the last allowed one.
    cnt_inc   = (xfer && burst_cnt != CNT_MAX) ? burst_cnt + CW'(1) : burst_cnt;
    force_sw  = granted & req_oth & ~lock_cur & (cnt_inc == CNT_MAX);
  end

  arb_pick u_pick (
    .req       ({m1_req, m0_req}),
    .last_gnt  (last_gnt),
    .cur_owner (owner),
    .granted   (granted),
    .hold      (hold),
    .force_sw  (force_sw),
    .nxt_valid (nxt_valid),
    .nxt_owner (nxt_owner)
  );

  always_comb begin
    state_nxt = IDLE;
    mem_wr_en = 1'b0;
    mem_rd_en = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (nxt_valid) begin
      state_nxt = nxt_owner ? GNT1 : GNT0;
    end
    if (xfer) begin
      mem_wr_en = we_cur;
      mem_rd_en = ~we_cur;
      mem_addr  = addr_cur;
      mem_wdata = wdata_cur;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      last_gnt  <= M_LDR;
      burst_cnt <= '0;
      rd_vld_q  <= 1'b0;
      rd_own_q  <= M_CPU;
    end else begin
      state    <= state_nxt;
      rd_vld_q <= mem_rd_en;
      rd_own_q <= owner;
      if (state_nxt != state) begin
        burst_cnt <= '0;
        if (granted) begin
          last_gnt <= owner;
        end
      end else begin
        burst_cnt <= cnt_inc;
      end
    end
  end

  assign m0_gnt    = (state == GNT0);
  assign m1_gnt    = (state == GNT1);
  // The RAM answers one cycle after the strobe; the tag steers it to whoever issued it.
  assign m0_rvalid = rd_vld_q & (rd_own_q == M_CPU);
  assign m1_rvalid = rd_vld_q & (rd_own_q == M_LDR);
  assign m0_rdata  = m0_rvalid ? mem_rdata : '0;
  assign m1_rdata  = m1_rvalid ? mem_rdata : '0;

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Two-master arbiter for the single-port program/data RAM.
- Master 0 is the CPU; master 1 is the loader/DMA engine that writes program images into RAM.
- Uses split read and write data buses, so it has no tristates inside. The top level keeps the shared `data_bus` tristate toward the RAM.
- Grants one master per burst, muxes its address, write data and write enable onto the RAM port, and routes RAM read data back with a 1-cycle read latency.

Parameters:
- ADDR_W, `` `ADDR_SIZE ``: address width.
- DATA_W, `` `WORD_SIZE ``: data width.
- MAX_BURST, 8: maximum unlocked transfers per grant while the other master is requesting.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- m0_req  in  1  CPU requests the bus.
- m0_we  in  1  CPU write (1) / read (0).
- m0_lock  in  1  CPU holds the grant regardless of MAX_BURST.
- m0_addr  in  ADDR_W  CPU address.
- m0_wdata  in  DATA_W  CPU write data.
- m0_gnt  out  1  CPU owns the bus.
- m0_rvalid  out  1  CPU read data valid.
- m0_rdata  out  DATA_W  CPU read data.
- m1_req, m1_we, m1_lock, m1_addr, m1_wdata, m1_gnt, m1_rvalid, m1_rdata: same as above, for the loader.
- mem_wr_en  out  1  RAM write enable.
- mem_rd_en  out  1  RAM read strobe.
- mem_addr  out  ADDR_W  RAM address.
- mem_wdata  out  DATA_W  RAM write data.
- mem_rdata  in  DATA_W  RAM read data; valid the cycle after mem_rd_en.

Behaviour:
- Reset (rst=0, asynchronous):
  - State = IDLE; last_gnt = 1, so m0 wins the first tie.
  - burst_cnt = 0.
  - All gnt, rvalid, mem_wr_en and mem_rd_en = 0; all rdata, mem_addr and mem_wdata = 0.
  - Reset mid-burst aborts the burst immediately. No write completes after rst falls.
- FSM states: IDLE, GNT0, GNT1.
- IDLE:
  - Requests are sampled at edge N; gnt is registered and rises at N+1.
  - Only one master requesting: that master is granted.
  - Both requesting: the master other than last_gnt is granted (round-robin).
  - No request: stay in IDLE.
- GNTx, transfers:
  - Every cycle with mx_req=1 is one transfer.
  - The mem_* outputs are a combinational mux of the granted master's signals gated by req.
  - Write: mem_wr_en = mx_we; no response.
  - Read: mem_rd_en = 1; mx_rvalid = 1 and mx_rdata = mem_rdata (registered) at the next cycle.
  - mem_* = 0 whenever no master is granted or the granted master's req = 0.
- burst_cnt:
  - Counts transfers in the current grant; saturates at MAX_BURST.
  - Cleared on every grant change.
- GNTx, leaving the state:
  - The granted master drops req with lock=0: go to GNTy if the other master requests, else IDLE. last_gnt = x.
  - burst_cnt == MAX_BURST, other master requesting, and mx_lock=0: forced switch to GNTy, even though req is still high.
  - mx_lock=1: hold the grant indefinitely, even with req=0 (idle locked cycles, no mem activity).
- Handover is registered: old gnt falls and new gnt rises on the same edge. Exactly one master transfers per cycle, with no dead cycle.
- Read data in flight at a handover is still returned to the issuing master via a registered owner tag.
- Invariants:
  - m0_gnt & m1_gnt is never 1.
  - mem_wr_en & mem_rd_en is never 1.

Optional Feature:
- Macro: ARB_FIXED_PRIO_EN.
- Defined:
  - m1 (loader) strictly wins every arbitration and every tie.
  - The MAX_BURST forced switch applies only to m0, so the loader can preempt the CPU but is never preempted.
  - last_gnt is ignored.
- Undefined: round-robin and MAX_BURST apply symmetrically, as described above.

Decomposition:
- Package mem_arb_pkg:
  - State enum {IDLE, GNT0, GNT1}.
  - Master index constants M_CPU=0, M_LDR=1.
  - Burst counter width function clog2(MAX_BURST+1).
- Sub-module arb_pick: combinational next-owner picker.
  - Inputs: req[1:0], last_gnt, cur_owner, force.
  - Output: next owner.
  - Contains the ARB_FIXED_PRIO_EN branch.
- Top level: FSM, burst counter, muxes, read-return tag.

Test Plan:
- Reset then m0_req=1, read addr 0x10, RAM holds 0xA5 -> m0_gnt rises 1 cycle later; mem_rd_en=1, mem_addr=0x10; m0_rvalid=1 with m0_rdata=0xA5 on the following cycle.
- m0 and m1 both request from IDLE after reset -> m0 granted first. After m0 releases, m1 is granted with zero dead cycles; on the next tie m0 wins again.
- m1 streams 12 writes 0x00..0x0B while m0_req is held, lock=0 -> after 8 writes, m1_gnt=0 and m0_gnt=1. m1 resumes after m0 releases, and RAM holds all 12 words.
- Same as the previous case with m1_lock=1 -> all 12 writes are uninterrupted; m0_gnt stays 0 until m1 drops both lock and req.
- m1 mid-write burst at addr 0x20, then rst pulsed low for 2 cycles -> all outputs 0 asynchronously; no mem_wr_en during reset; IDLE after release.
- With ARB_FIXED_PRIO_EN defined, m0 in a 20-transfer burst when m1 requests -> m1 is granted after at most 8 m0 transfers, and m0 never preempts m1.
